// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: frame check, E0/F0 prefix folding, event FIFO with valid/ready output.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [10:0] frame,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_break,
    output logic        frame_err,
    output logic        overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t             state, state_next;
    key_event_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, rd_next, wr_ptr, wr_next;
    logic [CNT_W-1:0]   count, count_next;
    key_event_t         evt, head_next;
    logic               evt_req, push, pop, full, drop, err_next, parity_ok, frame_ok;
    logic [7:0]         data;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^frame[9:1];
`else
    // parity bit deliberately ignored in this build
    assign parity_ok = frame[9] | 1'b1;
`endif

    assign data     = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & parity_ok;

    // Prefix FSM, FIFO bookkeeping and next-cycle head/flag values
    always_comb begin
        state_next = state;
        evt_req    = 1'b0;
        err_next   = 1'b0;
        evt.code   = data;
        evt.ext    = (state == EXT) || (state == EXT_BRK);
        evt.brk    = (state == BRK) || (state == EXT_BRK);

        if (frame_valid) begin
            if (!frame_ok) begin
                err_next   = 1'b1;
                state_next = IDLE;
            end else begin
                case (data)
                    8'hE0: begin
                        if (state == IDLE)     state_next = EXT;
                        else if (state == BRK) state_next = EXT_BRK;
                    end
                    8'hF0: begin
                        if (state == IDLE)     state_next = BRK;
                        else if (state == EXT) state_next = EXT_BRK;
                    end
                    default: begin
                        evt_req    = 1'b1;
                        state_next = IDLE;
                    end
                endcase
            end
        end

        full = (count == CNT_W'(FIFO_DEPTH));
        pop  = (count != '0) && key_ready;
        push = evt_req && (!full || pop);
        drop = evt_req && full && !pop;

        count_next = count;
        if (push && !pop)      count_next = count + CNT_W'(1);
        else if (pop && !push) count_next = count - CNT_W'(1);

        rd_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;

        // a freshly pushed entry becomes head only when nothing older remains
        if (count_next == '0)                head_next = '0;
        else if (push && (wr_ptr == rd_next)) head_next = evt;
        else                                  head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_next;
            count     <= count_next;
            key_valid <= (count_next != '0);
            key_code  <= head_next.code;
            key_ext   <= head_next.ext;
            key_break <= head_next.brk;
            frame_err <= err_next;
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt;
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: queue-based event model plus directed literal checks.
module tb_ps2_scancode_decoder;

    localparam int unsigned DEPTH = 4;
`ifdef PS2_PARITY_CHECK_EN
    localparam logic [10:0] F0_FRM = 11'h7E0;
`else
    localparam logic [10:0] F0_FRM = 11'h5E0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_valid = 1'b0;
    logic [10:0] frame = '0;
    logic        key_ready = 1'b0;
    logic        key_valid, key_ext, key_break, frame_err, overflow;
    logic [7:0]  key_code;

    int total = 0;
    int bad   = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
        .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: pending prefix flags and a queue of {code, ext, brk}
    logic [9:0] q[$];
    bit         m_ext, m_brk, m_err, m_ovf;

    always @(posedge clk) begin
        bit         ok;
        logic [7:0] b;
        m_err = 0;
        if (!reset) begin
            q.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0;
        end else begin
            if (q.size() > 0 && key_ready) void'(q.pop_front());
            if (frame_valid) begin
                b  = frame[8:1];
                ok = (frame[0] == 1'b0) && (frame[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
                if (($countones(frame[9:1]) % 2) != 1) ok = 0;
`endif
                if (!ok) begin
                    m_err = 1; m_ext = 0; m_brk = 0;
                end else if (b == 8'hE0) begin
                    m_ext = 1;
                end else if (b == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    if (q.size() < DEPTH) q.push_back({b, m_ext, m_brk});
                    else m_ovf = 1;
                    m_ext = 0; m_brk = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [9:0] h;
        h = (q.size() > 0) ? q[0] : 10'h0;
        chk("key_valid", 32'(key_valid), 32'(q.size() > 0));
        chk("key_code",  32'(key_code),  32'(h[9:2]));
        chk("key_ext",   32'(key_ext),   32'(h[1]));
        chk("key_break", 32'(key_break), 32'(h[0]));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    end

    function automatic logic [10:0] mk(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send(input logic [10:0] f);
        frame = f; frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); reset = 1'b1;
    endtask

    task automatic drain();
        int i;
        key_ready = 1'b1;
        for (i = 0; i < 20 && q.size() != 0; i++) tick();
        if (i == 20) chk("drain_timeout", 32'(q.size()), 32'd0);
        key_ready = 1'b0;
        tick();
    endtask

    task automatic drain_count(output int n);
        key_ready = 1'b1; n = 0;
        for (int i = 0; i < 8; i++) begin
            if (key_valid) n++;
            tick();
        end
        key_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b1; tick();

        // single make code
        send(11'h438);
        chk("mk_valid", 32'(key_valid), 32'd1);
        chk("mk_code",  32'(key_code),  32'h1C);
        chk("mk_flags", 32'({key_ext, key_break}), 32'd0);
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        chk("mk_popped", 32'(key_valid), 32'd0);

        // F0 1C -> break event, nothing after F0 alone
        send(F0_FRM);
        chk("f0_noevt", 32'(key_valid), 32'd0);
        send(11'h438);
        chk("brk_code",  32'(key_code), 32'h1C);
        chk("brk_flags", 32'({key_ext, key_break}), 32'b01);
        drain();

        // E0 F0 75 -> extended break
        send(11'h5C0); send(F0_FRM); send(11'h4EA);
        chk("eb_code",  32'(key_code), 32'h75);
        chk("eb_flags", 32'({key_ext, key_break}), 32'b11);
        drain();

        // E0 14 and a plain AA back-to-back
        send(mk(8'hE0)); send(mk(8'h14)); send(mk(8'hAA));
        chk("ext_code",  32'(key_code), 32'h14);
        chk("ext_flags", 32'({key_ext, key_break}), 32'b10);
        drain();

        // bad parity, bad start
        send(11'h638);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_err",   32'(frame_err), 32'd1);
        chk("par_noevt", 32'(key_valid), 32'd0);
`else
        chk("par_ign_code", 32'(key_code),  32'h1C);
        chk("par_ign_err",  32'(frame_err), 32'd0);
`endif
        drain();
        send(11'h5C0); send(11'h439);
        chk("start_err", 32'(frame_err), 32'd1);
        tick();
        chk("err_pulse", 32'(frame_err), 32'd0);
        send(11'h438);
        chk("err_clr_prefix", 32'({key_ext, key_break}), 32'd0);
        drain();

        // overflow: five frames into a 4-deep FIFO
        for (int i = 0; i < 5; i++) send(11'h438);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain_count(n);
        chk("ovf_drain_n", 32'(n), 32'd4);
        chk("ovf_sticky",  32'(overflow), 32'd1);

        // full with simultaneous push and pop
        do_reset();
        chk("ovf_rst", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) send(mk(8'(8'h10 + i)));
        frame = mk(8'h22); frame_valid = 1'b1; key_ready = 1'b1;
        tick();
        frame_valid = 1'b0; key_ready = 1'b0;
        chk("full_pp_ovf",  32'(overflow), 32'd0);
        chk("full_pp_head", 32'(key_code), 32'h11);
        drain_count(n);
        chk("full_pp_n", 32'(n), 32'd4);

        // reset mid-prefix discards the E0
        send(11'h5C0);
        reset = 1'b0; tick();
        chk("midrst_outs", 32'({key_valid, key_code, key_ext, key_break, frame_err, overflow}), 32'd0);
        reset = 1'b1;
        send(11'h438);
        chk("midrst_ext", 32'(key_ext), 32'd0);
        chk("midrst_code", 32'(key_code), 32'h1C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
